// File: rtl/spi_minion_channel_adapter.sv
// SPI minion that exchanges fixed-width frames with a host and bridges them to
// per-channel val/rdy queues: push frames feed out-queues, pull frames drain in-queues.
module spi_minion_channel_adapter_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_enq,
    input  logic [W-1:0] i_enq_data,
    input  logic         i_deq,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_enq;
    logic          w_deq;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];
    // Non-bypass: a full queue refuses writes even if it is read this cycle.
    assign w_enq   = i_enq & ~o_full;
    assign w_deq   = i_deq & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wp] <= i_enq_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_enq) r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            if (w_deq) r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
        end
    end
endmodule

module spi_minion_channel_adapter #(
    parameter int nbits        = 10,
    parameter int num_channels = 2,
    parameter int num_entries  = 2,
    localparam int abits = (num_channels > 1) ? $clog2(num_channels) : 1,
    localparam int dbits = nbits - 2 - abits
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          sclk,
    input  logic                          mosi,
    output logic                          miso,
    input  logic [num_channels*dbits-1:0] recv_msg,
    input  logic [num_channels-1:0]       recv_val,
    output logic [num_channels-1:0]       recv_rdy,
    output logic [num_channels*dbits-1:0] send_msg,
    output logic [num_channels-1:0]       send_val,
    input  logic [num_channels-1:0]       send_rdy,
    output logic [num_channels-1:0]       overflow
);
    localparam int CNTW = $clog2(nbits + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, COMMIT = 2'd3} state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]       r_cs_sync;
    logic [1:0]       r_sclk_sync;
    logic [1:0]       r_mosi_sync;
    logic [1:0]       r_warm;
    logic             r_cs_prev;
    logic             r_sclk_prev;
    logic             r_armed;
    logic             w_cs_fall;
    logic             w_cs_rise;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_load;
    logic             w_shift;
    logic             w_commit;

    logic [nbits-1:0] r_sr;
    logic [CNTW-1:0]  r_cnt;
    logic             r_miso;
    logic [abits-1:0] r_sel;
    logic             r_rd_pending;
    logic [num_channels-1:0] r_overflow;

    logic             w_wrt;
    logic             w_rd;
    logic [abits-1:0] w_addr;
    logic [dbits-1:0] w_data;
    logic             w_addr_ok;
    logic             w_frame_ok;
    logic             w_pull_val;
    logic             w_pull_spc;
    logic [dbits-1:0] w_pull_data;
    logic [nbits-1:0] w_pull;

    logic [num_channels-1:0]            w_out_full;
    logic [num_channels-1:0]            w_out_empty;
    logic [num_channels-1:0]            w_out_enq;
    logic [num_channels-1:0]            w_in_full;
    logic [num_channels-1:0]            w_in_empty;
    logic [num_channels-1:0]            w_in_deq;
    logic [num_channels-1:0][dbits-1:0] w_in_head;

    // The warm-up shift keeps the reset value of the cs synchroniser from arming
    // the minion; only a genuinely sampled high cs does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_sync   <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
            r_warm      <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_cs_prev   <= r_cs_sync[1];
            r_sclk_prev <= r_sclk_sync[1];
            r_warm      <= {r_warm[0], 1'b1};
            if (r_warm[1] && r_cs_sync[1]) r_armed <= 1'b1;
        end
    end

    assign w_cs_fall   =  r_cs_prev   & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_prev   &  r_cs_sync[1];
    assign w_sclk_rise = ~r_sclk_prev &  r_sclk_sync[1];
    assign w_sclk_fall =  r_sclk_prev & ~r_sclk_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall && r_armed) w_next = LOAD;
            LOAD:    w_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            LOAD:    w_load   = 1'b1;
            SHIFT:   w_shift  = 1'b1;
            COMMIT:  w_commit = 1'b1;
            default: ;
        endcase
    end

    assign w_wrt      = r_sr[nbits-1];
    assign w_rd       = r_sr[nbits-2];
    assign w_addr     = r_sr[nbits-3 -: abits];
    assign w_data     = r_sr[dbits-1:0];
    assign w_addr_ok  = (32'(w_addr) < num_channels);
    assign w_frame_ok = (r_cnt == CNTW'(nbits));

    assign w_pull_val  = r_rd_pending & ~w_in_empty[r_sel];
    assign w_pull_data = w_pull_val ? w_in_head[r_sel] : '0;
    assign w_pull_spc  = ~w_out_full[r_sel];
    assign w_pull      = {w_pull_val, w_pull_spc, r_sel, w_pull_data};

    // One shift register serves both directions: the pull frame leaves from the
    // MSB while host bits enter at the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr         <= '0;
            r_cnt        <= '0;
            r_miso       <= 1'b0;
            r_sel        <= '0;
            r_rd_pending <= 1'b0;
            r_overflow   <= '0;
        end else begin
            if (w_load) begin
                r_sr         <= w_pull;
                r_cnt        <= '0;
                r_miso       <= w_pull[nbits-1];
                r_rd_pending <= 1'b0;
            end
            if (w_shift) begin
                if (w_sclk_rise) begin
                    r_sr <= {r_sr[nbits-2:0], r_mosi_sync[1]};
                    if (r_cnt != CNTW'(nbits + 1)) r_cnt <= r_cnt + CNTW'(1);
                end
                if (w_sclk_fall) r_miso <= r_sr[nbits-1];
            end
            if (w_commit && w_frame_ok) begin
                if (w_addr_ok) begin
                    r_sel <= w_addr;
                    if (w_wrt && w_out_full[w_addr]) r_overflow[w_addr] <= 1'b1;
                end
                if (w_rd) r_rd_pending <= 1'b1;
            end
        end
    end

    assign miso     = r_miso;
    assign overflow = r_overflow;

    for (genvar c = 0; c < num_channels; c++) begin : g_ch
        assign w_out_enq[c] = w_commit & w_frame_ok & w_wrt & w_addr_ok & (w_addr == abits'(c));
        assign w_in_deq[c]  = w_load & w_pull_val & (r_sel == abits'(c));

        spi_minion_channel_adapter_fifo #(.W(dbits), .DEPTH(num_entries)) u_out (
            .clk        (clk),
            .reset      (reset),
            .i_enq      (w_out_enq[c]),
            .i_enq_data (w_data),
            .i_deq      (send_rdy[c]),
            .o_full     (w_out_full[c]),
            .o_empty    (w_out_empty[c]),
            .o_head     (send_msg[c*dbits +: dbits])
        );

        spi_minion_channel_adapter_fifo #(.W(dbits), .DEPTH(num_entries)) u_in (
            .clk        (clk),
            .reset      (reset),
            .i_enq      (recv_val[c]),
            .i_enq_data (recv_msg[c*dbits +: dbits]),
            .i_deq      (w_in_deq[c]),
            .o_full     (w_in_full[c]),
            .o_empty    (w_in_empty[c]),
            .o_head     (w_in_head[c])
        );

        assign send_val[c] = ~w_out_empty[c];
        assign recv_rdy[c] = ~w_in_full[c];
    end
endmodule

// File: tb/tb_spi_minion_channel_adapter.sv
// Bench for spi_minion_channel_adapter: directed SPI frames against a queue-level
// model of the channel queues, overflow flags, selected channel and pending read.
module tb_spi_minion_channel_adapter;
    localparam int NB = 10;
    localparam int NC = 2;
    localparam int NE = 2;
    localparam int DB = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic [NC*DB-1:0] recv_msg;
    logic [NC-1:0]    recv_val;
    logic [NC-1:0]    recv_rdy;
    logic [NC*DB-1:0] send_msg;
    logic [NC-1:0]    send_val;
    logic [NC-1:0]    send_rdy;
    logic [NC-1:0]    overflow;

    always #5 clk = ~clk;

    spi_minion_channel_adapter #(.nbits(NB), .num_channels(NC), .num_entries(NE)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .overflow (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int        oq [NC][$];
    int        iq [NC][$];
    bit [NC-1:0] m_ovf;
    int        m_sel;
    bit        m_rdp;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            oq[c].delete();
            iq[c].delete();
        end
        m_ovf = '0;
        m_sel = 0;
        m_rdp = 1'b0;
    endtask

    // What the host should see on miso for the frame about to start.
    task automatic model_load(output logic [NB-1:0] pull);
        bit val;
        int data;
        val  = m_rdp && (iq[m_sel].size() > 0);
        data = val ? iq[m_sel].pop_front() : 0;
        pull = {val, (oq[m_sel].size() < NE) ? 1'b1 : 1'b0, m_sel[0], data[DB-1:0]};
        m_rdp = 1'b0;
    endtask

    task automatic model_commit(input logic [NB-1:0] push, input int nb);
        int a;
        if (nb != NB) return;
        a = int'(push[NB-3]);
        m_sel = a;
        if (push[NB-1]) begin
            if (oq[a].size() < NE) oq[a].push_back(int'(push[DB-1:0]));
            else m_ovf[a] = 1'b1;
        end
        if (push[NB-2]) m_rdp = 1'b1;
    endtask

    // Continuous check of design-side outputs whenever no frame is in flight.
    always @(posedge clk) begin
        #2;
        if (chk_en && !reset) begin
            for (int c = 0; c < NC; c++) begin
                chk("send_val", send_val[c], (oq[c].size() > 0) ? 1 : 0);
                if (oq[c].size() > 0) chk("send_msg", send_msg[c*DB +: DB], oq[c][0]);
                chk("recv_rdy", recv_rdy[c], (iq[c].size() < NE) ? 1 : 0);
            end
            chk("overflow", overflow, int'(m_ovf));
        end
    end

    task automatic frame(input logic [NB-1:0] push, input int nb, input logic [NC-1:0] rdy_pulse,
                         output logic [NB-1:0] pulled);
        logic [NB-1:0] exp_pull;
        logic [NB-1:0] p;
        int k;
        chk_en = 1'b0;
        model_load(exp_pull);
        p = '0;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            mosi = (i < NB) ? push[NB-1-i] : 1'b0;
            repeat (4) @(negedge clk);
            p = {p[NB-2:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        if (rdy_pulse != '0) begin
            k = 0;
            while (dut.r_state != 2'd3 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("commit_reached", (k < 20) ? 1 : 0, 1);
            send_rdy = send_rdy | rdy_pulse;
            for (int c = 0; c < NC; c++)
                if (rdy_pulse[c] && oq[c].size() > 0) void'(oq[c].pop_front());
            @(negedge clk);
            send_rdy = send_rdy & ~rdy_pulse;
        end
        repeat (8) @(negedge clk);
        model_commit(push, nb);
        if (nb <= NB) chk("pull_frame", p, int'(exp_pull >> (NB - nb)));
        pulled = p;
        chk_en = 1'b1;
    endtask

    task automatic design_enq(input int c, input logic [DB-1:0] d);
        @(negedge clk);
        recv_msg[c*DB +: DB] = d;
        recv_val[c] = 1'b1;
        if (iq[c].size() < NE) iq[c].push_back(int'(d));
        @(negedge clk);
        recv_val[c] = 1'b0;
    endtask

    task automatic design_deq(input int c, input int exp);
        @(negedge clk);
        chk("deq_val", send_val[c], 1);
        chk("deq_data", send_msg[c*DB +: DB], exp);
        send_rdy[c] = 1'b1;
        if (oq[c].size() > 0) void'(oq[c].pop_front());
        @(negedge clk);
        send_rdy[c] = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] pl;
        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        recv_msg = '0; recv_val = '0; send_rdy = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_send_val", send_val, 0);
        chk("rst_recv_rdy", recv_rdy, 3);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk_en = 1'b1;

        // Write to channel 1.
        frame(10'h2AA, NB, 2'b00, pl);
        chk("wr_pull", pl, 10'h100);
        chk("wr_send_val", send_val, 2'b10);
        chk("wr_send_msg1", send_msg[DB +: DB], 7'h2A);
        design_deq(1, 7'h2A);

        // Read from channel 0, filling its in-queue first.
        design_enq(0, 7'h55);
        design_enq(0, 7'h66);
        @(negedge clk);
        chk("rd_recv_rdy_full", recv_rdy, 2'b10);
        frame(10'h100, NB, 2'b00, pl);
        chk("rd_req_pull", pl, 10'h180);
        frame(10'h000, NB, 2'b00, pl);
        chk("rd_data_pull", pl, 10'h355);
        chk("rd_recv_rdy", recv_rdy, 2'b11);
        frame(10'h000, NB, 2'b00, pl);
        chk("rd_pending_cleared", pl, 10'h100);

        // Overflow on channel 0 with the design stalled.
        frame(10'h211, NB, 2'b00, pl);
        frame(10'h222, NB, 2'b00, pl);
        frame(10'h233, NB, 2'b00, pl);
        chk("ovf_third_pull", pl, 10'h000);
        chk("ovf_flag", overflow, 2'b01);
        frame(10'h000, NB, 2'b00, pl);
        chk("ovf_spc0", pl, 10'h000);
        design_deq(0, 7'h11);
        design_deq(0, 7'h22);

        // Short and over-long frames are discarded; a normal one follows.
        frame(10'h2AA, 6, 2'b00, pl);
        chk("short_send_val", send_val, 0);
        frame(10'h2AA, 12, 2'b00, pl);
        chk("long_send_val", send_val, 0);
        frame(10'h2B3, NB, 2'b00, pl);
        chk("after_short_val", send_val, 2'b10);
        chk("after_short_msg", send_msg[DB +: DB], 7'h33);
        design_deq(1, 7'h33);

        // Reset in the middle of a frame with cs held low.
        chk_en = 1'b0;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_send_val", send_val, 0);
        chk("mid_rst_recv_rdy", recv_rdy, 3);
        chk("mid_rst_overflow", overflow, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            mosi = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_start_send_val", send_val, 0);
        frame(10'h2AA, NB, 2'b00, pl);
        chk("post_rst_pull", pl, 10'h100);
        chk("post_rst_send_val", send_val, 2'b10);

        // Commit into channel 1 while the design dequeues it in the same cycle.
        frame(10'h2CC, NB, 2'b10, pl);
        chk("simul_send_val", send_val, 2'b10);
        chk("simul_head", send_msg[DB +: DB], 7'h4C);
        frame(10'h2D5, NB, 2'b00, pl);
        design_deq(1, 7'h4C);
        design_deq(1, 7'h55);
        repeat (4) @(negedge clk);
        chk("final_send_val", send_val, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
